// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - single-clock AXI4-Stream FIFO with occupancy flags and optional store-and-forward
module axis_pkt_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0,
  parameter int AF_THRESH   = DEPTH - 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                        axis_clk,
  input  logic                        axis_rst,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic [$clog2(DEPTH):0]      fill_level,
  output logic [$clog2(DEPTH):0]      pkt_count,
  output logic                        almost_full,
  output logic                        almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam logic [AW:0] AF_LVL = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL = (AW + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [KW-1:0]         r_mem_keep [DEPTH];
  logic                  r_mem_last [DEPTH];

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_fill;
  logic [AW:0] r_pkt;
  logic        r_ovr;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;
  logic w_wr_last;
  logic w_rd_last;
  logic w_ovr_set;

  // Pointers differ only in the wrap bit when full, and match exactly when empty.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign s_axis_tready = !w_full;
  // In packet mode the head is only offered once a whole packet is stored, or when
  // an oversize packet has filled the buffer and must be streamed out to avoid deadlock.
  assign m_axis_tvalid = !w_empty && ((PACKET_MODE == 0) || (r_pkt != '0) || r_ovr);

  assign w_wr      = s_axis_tvalid && s_axis_tready;
  assign w_rd      = m_axis_tvalid && m_axis_tready;
  assign w_wr_last = w_wr && s_axis_tlast;
  assign w_rd_last = w_rd && m_axis_tlast;
  assign w_ovr_set = (PACKET_MODE != 0) && w_full && (r_pkt == '0);

  assign m_axis_tdata = r_mem_data[r_rd_ptr[AW-1:0]];
  assign m_axis_tkeep = r_mem_keep[r_rd_ptr[AW-1:0]];
  assign m_axis_tlast = r_mem_last[r_rd_ptr[AW-1:0]];

  assign fill_level   = r_fill;
  assign pkt_count    = r_pkt;
  assign almost_full  = (r_fill >= AF_LVL);
  assign almost_empty = (r_fill <= AE_LVL);

  // Storage array is not reset; contents are only meaningful behind valid pointers.
  always_ff @(posedge axis_clk) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
      r_mem_keep[r_wr_ptr[AW-1:0]] <= s_axis_tkeep;
      r_mem_last[r_wr_ptr[AW-1:0]] <= s_axis_tlast;
    end
  end

  // Pointer advance on handshakes; pointers wrap naturally through the extra MSB.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Word and packet occupancy counters; simultaneous in/out leaves them unchanged.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_fill <= '0;
      r_pkt  <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      case ({w_wr_last, w_rd_last})
        2'b10:   r_pkt <= r_pkt + 1'b1;
        2'b01:   r_pkt <= r_pkt - 1'b1;
        default: r_pkt <= r_pkt;
      endcase
    end
  end

  // Oversize override: latched when the buffer fills without a complete packet,
  // released once the tail of that packet leaves.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_ovr <= 1'b0;
    end else if (w_rd_last) begin
      r_ovr <= 1'b0;
    end else if (w_ovr_set) begin
      r_ovr <= 1'b1;
    end
  end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
Single-clock AXI4-Stream data FIFO with TLAST/TKEEP sideband, occupancy reporting, programmable almost-full/almost-empty flags and an optional packet (store-and-forward) mode. It sits between AXIS producers and consumers in one clock domain. It buffers data and decouples backpressure. Writes and reads are qualified strictly by the valid&&ready handshake.

Parameters:
DATA_WIDTH, 32, tdata width in bits; multiple of 8.
DEPTH, 16, number of entries; power of 2, minimum 4.
PACKET_MODE, 0, 0 = cut-through; 1 = store-and-forward (hold output until a full packet is stored).
AF_THRESH, DEPTH-2, almost_full asserts when fill_level >= AF_THRESH.
AE_THRESH, 2, almost_empty asserts when fill_level <= AE_THRESH.

Ports:
axis_clk  in  1  clock; all logic rising-edge.
axis_rst  in  1  asynchronous, active-high reset.
s_axis_tvalid  in  1  slave valid.
s_axis_tready  out  1  slave ready; equals !full.
s_axis_tdata  in  DATA_WIDTH  write data.
s_axis_tkeep  in  DATA_WIDTH/8  byte qualifiers; stored unmodified.
s_axis_tlast  in  1  end of packet.
m_axis_tvalid  out  1  master valid.
m_axis_tready  in  1  master ready.
m_axis_tdata  out  DATA_WIDTH  read data.
m_axis_tkeep  out  DATA_WIDTH/8  read byte qualifiers.
m_axis_tlast  out  1  read end of packet.
fill_level  out  $clog2(DEPTH)+1  stored word count, 0..DEPTH.
pkt_count  out  $clog2(DEPTH)+1  number of complete packets (stored TLASTs) not yet read.
almost_full  out  1  fill_level >= AF_THRESH.
almost_empty  out  1  fill_level <= AE_THRESH.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH + DATA_WIDTH/8 + 1) register array.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits and wrap naturally.
- Full and empty are derived from the pointers: equal pointers except the MSB means full; fully equal pointers means empty.
- Write event: wr = s_axis_tvalid && s_axis_tready. Read event: rd = m_axis_tvalid && m_axis_tready. No storage or pointer change occurs without the handshake.
- First-word-fall-through: m_axis_tdata/tkeep/tlast are driven combinationally from mem[rd_ptr]. They are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Latency, cut-through: a word written on edge N makes m_axis_tvalid=1 after edge N (visible in cycle N+1).
- Latency, packet mode: m_axis_tvalid=1 only when pkt_count>0 or the oversize override is active. The first word becomes visible in the cycle after the TLAST word is written.
- fill_level and pkt_count are registered counters:
  - +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - pkt_count moves on written/read beats that carry TLAST.
- almost_full and almost_empty are combinational compares of registered fill_level.
- Full: s_axis_tready=0. No write-through when full, even if a read occurs in the same cycle; tready rises in the cycle after the read.
- Empty: m_axis_tvalid=0. No read-through of same-cycle input.
- Simultaneous read and write when neither full nor empty: both occur; fill_level holds.
- Oversize override (PACKET_MODE=1 only): if full && pkt_count==0, set override_q. While it is set, m_axis_tvalid=!empty. Clear it on the read of a TLAST beat. This prevents deadlock on packets longer than DEPTH.
- PACKET_MODE=0: pkt_count is still maintained; override logic is absent.
- Reset (asynchronous assert, synchronous-to-clock deassert handled externally):
  - pointers, counters and override_q = 0;
  - outputs: s_axis_tready=1, m_axis_tvalid=0, fill_level=0, pkt_count=0, almost_full=0, almost_empty=1;
  - memory contents are not reset; m_axis_tdata is don't-care while tvalid=0.
- Reset mid-packet: all buffered data, including partial packets, is discarded. The FIFO is empty on the first clock after reset release.

Test Plan:
- Cut-through, DEPTH=8: write 8 beats 0x1..0x8 with m_axis_tready=0. Required: fill_level=8, s_axis_tready=0, almost_full=1. Then read all: out 0x1..0x8 in order, fill_level returns to 0, almost_empty=1.
- Simultaneous, DEPTH=8: with fill_level=4, hold s_axis_tvalid=m_axis_tready=1 for 20 cycles. Required: fill_level stays 4, 20 beats in and 20 out, data in order; pointer wrap crossed twice without corruption.
- Full plus read: with fill_level=8, assert write and read in the same cycle. Required: read occurs, write stalls, fill_level=7, s_axis_tready=1 next cycle.
- Packet mode, DEPTH=8: write a 3-beat packet, TLAST on beat 3, tkeep=0xF,0xF,0x3. Required: m_axis_tvalid=0 until the cycle after beat 3, then pkt_count=1. Read yields tlast only on beat 3 with tkeep=0x3; pkt_count returns to 0.
- Oversize, packet mode, DEPTH=8: write 10-beat packet, m_axis_tready=1. Required: after 8 beats full with pkt_count=0, override asserts, tvalid=1, all 10 beats drain in order, override clears after TLAST read.
- Reset mid-operation: fill_level=5, assert axis_rst asynchronously mid-cycle. Required: outputs immediately reach reset values (tvalid=0, fill_level=0, tready=1). After release, a new write then read returns only the new data.
